mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  MEM-stage data-memory controller between the EX/MEM and MEM/WB pipeline registers.
//  Issues load/store requests to a req/ack data memory, handles byte/half/word lanes and sign extension.
//  Stalls the pipeline while an access is outstanding; presents aligned ReadData to MEM/WB.
// PARAMETERS
//  TIMEOUT_CYC  255  max WAIT cycles without dmem_ack before bus error (1..65535)
// PORTS
//  clk              in   1   clock, rising edge
//  reset            in   1   asynchronous, active-high
//  mem_read_in      in   1   load in MEM stage (from EX/MEM)
//  mem_write_in     in   1   store in MEM stage (from EX/MEM)
//  mem_size_in      in   2   00 byte, 01 half, 10 word, 11 reserved (= word)
//  mem_unsigned_in  in   1   1: zero-extend loads (LBU/LHU), 0: sign-extend
//  addr_in          in   32  byte address (ALU result)
//  wdata_in         in   32  store data, right-justified
//  dmem_req         out  1   memory request
//  dmem_we          out  1   1 store, 0 load; valid with dmem_req
//  dmem_addr        out  32  word address {addr_in[31:2],2'b00}
//  dmem_be          out  4   byte enables (stores; 4'b1111 on loads)
//  dmem_wdata       out  32  lane-replicated store data
//  dmem_ack         in   1   memory completed request this cycle
//  dmem_rdata       in   32  load word, valid with dmem_ack
//  read_data_out    out  32  extended load data to MEM/WB ReadData_in
//  mem_stall        out  1   hold PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
//  bus_err          out  1   one-cycle pulse: access timed out
//  misalign_trap    out  1   one-cycle pulse: misaligned access (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): state IDLE, wait counter 0, read_data_out 0, bus_err 0, misalign_trap 0; dmem_req drops at once.
//  - access = mem_read_in | mem_write_in; both set -> store, no load data (read_data_out 0).
//  - FSM IDLE/WAIT/DONE:
//    IDLE: access -> dmem_req=1, mem_stall=1; ack same cycle -> DONE, else -> WAIT. No access -> stall 0.
//    WAIT: dmem_req=1, mem_stall=1, counter++; ack -> DONE; counter==TIMEOUT_CYC-1 w/o ack -> DONE, bus_err set.
//    DONE: dmem_req=0, mem_stall=0, read_data_out valid this cycle; -> IDLE unconditionally.
//  - Min access latency 2 cycles (req cycle + DONE); DONE guarantees the held access is never reissued.
//  - read_data_out, bus_err, misalign_trap registered on entry to DONE; cleared to 0 on leaving DONE.
//  - dmem_addr/be/wdata/we combinational from inputs (held stable by mem_stall).
//  - Little-endian lanes: byte lane = addr_in[1:0]; half lane = addr_in[1].
//    Store be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
//    Store data: byte replicated x4, half replicated x2, word as-is.
//    Load: select lane, extend to 32 per mem_unsigned_in; word unchanged.
//  - Timeout: bus_err pulses in DONE, read_data_out 0; dmem_ack arriving after timeout is ignored.
//  - Counter cleared on every IDLE entry.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no dmem_req,
//   IDLE -> DONE directly, misalign_trap=1 in DONE, read_data_out 0, store suppressed.
//  Undefined: offending low address bits ignored (half uses addr[1], word uses 00); misalign_trap tied 0.
// STRUCTURE
//  Package mem_pkg: size codes (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum, TIMEOUT_CYC default.
//  Sub-module mem_lane_align (combinational): store be/wdata generation, load lane extract + extension.
// TESTING
//  1 LB addr 0x103, rdata 0x80FF_1234, ack after 3 cycles -> stall 4 cycles, read_data_out 0xFFFF_FF80 in DONE.
//  2 SH addr 0x202 wdata 0x0000_ABCD -> dmem_be 4'b1100, dmem_wdata 0xABCD_ABCD, dmem_addr 0x200.
//  3 LHU addr 0x10, ack in req cycle, rdata 0x1234_F00D -> stall 1 cycle, read_data_out 0x0000_F00D.
//  4 LW, no ack, TIMEOUT_CYC=4 -> bus_err pulse in DONE, read_data_out 0, late ack ignored.
//  5 LW addr 0x6 with MISALIGN_TRAP_EN -> no dmem_req, misalign_trap pulse; without -> reads 0x4.
//  6 Reset asserted in WAIT -> dmem_req and mem_stall 0 immediately; next access starts cleanly in IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage data-memory controller: size codes, FSM states, defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  // A half needs an even address, a word (and the reserved code, treated as word) needs addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller and the data memory.
// Latency: n/a (signal bundle).
// Backpressure: memory holds off completion by withholding dmem_ack; requester holds fields stable.
interface mem_stage_ctrl_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte enables / replicated data, load lane extract + extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_dat,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_dat
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Pick the addressed byte and half out of the returned word.
  always_comb begin
    ld_byte = ld_word[7:0];
    case (addr_lo)
      2'b00: ld_byte = ld_word[7:0];
      2'b01: ld_byte = ld_word[15:8];
      2'b10: ld_byte = ld_word[23:16];
      2'b11: ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
  end

  // Size-dependent enables, store replication and load extension; reserved size behaves as word.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_dat;
    ld_dat   = ld_word;
    case (size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << addr_lo;
        st_wdata = {4{st_dat[7:0]}};
        ld_dat   = zero_ext ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        st_be    = 4'b0011 << {addr_lo[1], 1'b0};
        st_wdata = {2{st_dat[15:0]}};
        ld_dat   = zero_ext ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_dat;
        ld_dat   = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: issues load/store, stalls the pipe, returns extended ReadData.
// Latency: >= 2 cycles per access (request cycle + DONE); bus error after TIMEOUT_CYC WAIT cycles.
// Backpressure: mem_stall held while an access is outstanding; the memory stalls us by withholding dmem_ack.
// Optional: define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_size_in,
  input  logic        mem_unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  mem_stage_ctrl_if.master dmem,
  output logic [31:0] read_data_out,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        misalign_trap
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  mem_state_e  state_q, state_d;
  logic [15:0] cnt_q;
  logic        access, is_load, misal;
  logic        req_c, stall_c, timeout_c;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_dat;

  assign access  = mem_read_in | mem_write_in;
  // A simultaneous read+write is a store; it never produces load data.
  assign is_load = mem_read_in & ~mem_write_in;

`ifdef MISALIGN_TRAP_EN
  assign misal = access & is_misaligned(mem_size_in, addr_in[1:0]);
`else
  assign misal = 1'b0;
`endif

  mem_lane_align u_lane (
    .size     (mem_size_in),
    .zero_ext (mem_unsigned_in),
    .addr_lo  (addr_in[1:0]),
    .st_dat   (wdata_in),
    .ld_word  (dmem.dmem_rdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_dat   (ld_dat)
  );

  // Request fields come straight from EX/MEM; mem_stall keeps them stable for the whole access.
  assign dmem.dmem_we    = mem_write_in;
  assign dmem.dmem_addr  = {addr_in[31:2], 2'b00};
  assign dmem.dmem_be    = mem_write_in ? st_be : 4'b1111;
  assign dmem.dmem_wdata = st_wdata;

  // Reset gates the handshake outputs so they drop the instant reset rises, even with an access pending.
  assign dmem.dmem_req = req_c & ~reset;
  assign mem_stall     = stall_c & ~reset;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; DONE always returns to IDLE so a held access is not reissued.
  always_comb begin
    state_d   = state_q;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          stall_c = 1'b1;
          if (misal) begin
            state_d = ST_DONE;
          end else begin
            req_c   = 1'b1;
            state_d = dmem.dmem_ack ? ST_DONE : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (dmem.dmem_ack) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_DONE;
          timeout_c = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // WAIT-cycle counter: counts only while remaining in WAIT, zero everywhere else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == ST_WAIT && state_d == ST_WAIT) begin
      cnt_q <= cnt_q + 16'd1;
    end else begin
      cnt_q <= '0;
    end
  end

  // Result registers: loaded on entry to DONE, zeroed as DONE is left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_out <= '0;
      bus_err       <= 1'b0;
      misalign_trap <= 1'b0;
    end else if (state_d == ST_DONE && state_q != ST_DONE) begin
      read_data_out <= (is_load && !misal && !timeout_c) ? ld_dat : 32'd0;
      bus_err       <= timeout_c;
      misalign_trap <= misal && (state_q == ST_IDLE);
    end else if (state_q == ST_DONE) begin
      read_data_out <= '0;
      bus_err       <= 1'b0;
      misalign_trap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed accesses push expected request/completion records.
// Latency: a monitor on the falling edge pops and compares on request start and on each DONE cycle.
// Backpressure: a simple memory model delays dmem_ack per vector (or withholds it for the timeout case).
module tb_mem_stage_ctrl;
  import mem_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_exp_t;

  typedef struct {
    logic [31:0] rd;
    logic        berr;
    logic        mis;
    int          stall;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [1:0]  mem_size_in = 2'b00;
  logic        mem_unsigned_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] wdata_in = '0;
  logic [31:0] read_data_out;
  logic        mem_stall, bus_err, misalign_trap;

  mem_stage_ctrl_if dmem_bus();

  mem_stage_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .mem_size_in     (mem_size_in),
    .mem_unsigned_in (mem_unsigned_in),
    .addr_in         (addr_in),
    .wdata_in        (wdata_in),
    .dmem            (dmem_bus),
    .read_data_out   (read_data_out),
    .mem_stall       (mem_stall),
    .bus_err         (bus_err),
    .misalign_trap   (misalign_trap)
  );

  always #5 clk = ~clk;

  req_exp_t  req_q[$];
  done_exp_t done_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares request fields when dmem_req rises and results in the DONE cycle.
  logic prev_req = 1'b0;
  logic prev_stall = 1'b0;
  int   stall_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_req   = 1'b0;
      prev_stall = 1'b0;
      stall_cnt  = 0;
    end else begin
      if (dmem_bus.dmem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          req_exp_t r;
          r = req_q.pop_front();
          chk("req_addr", dmem_bus.dmem_addr, r.addr);
          chk("req_be", {28'd0, dmem_bus.dmem_be}, {28'd0, r.be});
          chk("req_wdata", dmem_bus.dmem_wdata, r.wdata);
          chk("req_we", {31'd0, dmem_bus.dmem_we}, {31'd0, r.we});
        end
      end
      if (!mem_stall && prev_stall) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          done_exp_t d;
          d = done_q.pop_front();
          chk("done_rdata", read_data_out, d.rd);
          chk("done_bus_err", {31'd0, bus_err}, {31'd0, d.berr});
          chk("done_misalign", {31'd0, misalign_trap}, {31'd0, d.mis});
          chk("done_stall_cycles", stall_cnt, d.stall);
        end
      end else begin
        chk("quiet_outputs", {bus_err, misalign_trap, 30'd0} | read_data_out, 32'd0);
      end
      stall_cnt  = mem_stall ? stall_cnt + 1 : 0;
      prev_req   = dmem_bus.dmem_req;
      prev_stall = mem_stall;
    end
  end

  // One access: push expectations, drive EX/MEM fields, model ack timing, then release the stage.
  task automatic run_access(
    input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
    input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
    input int ack_at, input logic late_ack, input logic exp_req,
    input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
    input logic [31:0] e_rd, input logic e_berr, input logic e_mis, input int e_stall);
    int  i;
    logic fin;
    if (exp_req) req_q.push_back('{e_addr, e_be, e_wdata, wr});
    done_q.push_back('{e_rd, e_berr, e_mis, e_stall});
    @(posedge clk); #1;
    mem_read_in = rd; mem_write_in = wr; mem_size_in = sz; mem_unsigned_in = uns;
    addr_in = addr; wdata_in = wd; dmem_bus.dmem_rdata = rdat;
    i = 0;
    fin = 1'b0;
    while (!fin && i < 40) begin
      dmem_bus.dmem_ack = (i == ack_at);
      @(posedge clk); #1;
      i++;
      if (!mem_stall) fin = 1'b1;
    end
    if (!fin) chk("access_completion_bound", 32'd0, 32'd1);
    dmem_bus.dmem_ack = late_ack;
    @(posedge clk); #1;
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    @(posedge clk); #1;
    dmem_bus.dmem_ack = 1'b0;
  endtask

  initial begin
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;
    // Reset state, including a load presented while reset is held.
    repeat (2) @(posedge clk);
    #1;
    mem_read_in = 1'b1;
    #1;
    chk("rst_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_rdata", read_data_out, 32'd0);
    chk("rst_flags", {30'd0, bus_err, misalign_trap}, 32'd0);
    mem_read_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // LB 0x103, ack on 4th request cycle: sign-extended byte 0x80.
    run_access(1, 0, SZ_BYTE, 0, 32'h103, 32'h0, 32'h80FF_1234, 3, 0, 1,
               32'h100, 4'hF, 32'h0, 32'hFFFF_FF80, 0, 0, 4);
    // SH 0x202: upper half lanes, replicated data.
    run_access(0, 1, SZ_HALF, 0, 32'h202, 32'h0000_ABCD, 32'h0, 0, 0, 1,
               32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 0, 1);
    // LHU 0x10, ack in request cycle.
    run_access(1, 0, SZ_HALF, 1, 32'h10, 32'h0, 32'h1234_F00D, 0, 0, 1,
               32'h10, 4'hF, 32'h0, 32'h0000_F00D, 0, 0, 1);
    // LW with no ack: timeout after 4 WAIT cycles, late ack ignored.
    run_access(1, 0, SZ_WORD, 0, 32'h20, 32'h0, 32'hDEAD_BEEF, -1, 1, 1,
               32'h20, 4'hF, 32'h0, 32'h0, 1, 0, 5);
    // LW 0x6: trapped when the misalign trap is built in, else read from 0x4.
`ifdef MISALIGN_TRAP_EN
    run_access(1, 0, SZ_WORD, 0, 32'h6, 32'h0, 32'hCAFE_F00D, 1, 0, 0,
               32'h0, 4'h0, 32'h0, 32'h0, 0, 1, 1);
`else
    run_access(1, 0, SZ_WORD, 0, 32'h6, 32'h0, 32'hCAFE_F00D, 1, 0, 1,
               32'h4, 4'hF, 32'h0, 32'hCAFE_F00D, 0, 0, 2);
`endif
    // LH 0x12: upper half sign-extended.
    run_access(1, 0, SZ_HALF, 0, 32'h12, 32'h0, 32'h8001_0000, 1, 0, 1,
               32'h10, 4'hF, 32'h0, 32'hFFFF_8001, 0, 0, 2);
    // SB 0x1: lane 1 enable, byte replicated.
    run_access(0, 1, SZ_BYTE, 0, 32'h1, 32'h1234_5678, 32'h0, 0, 0, 1,
               32'h0, 4'b0010, 32'h7878_7878, 32'h0, 0, 0, 1);
    // LBU 0x2: lane 2 zero-extended.
    run_access(1, 0, SZ_BYTE, 1, 32'h2, 32'h0, 32'h00AB_0000, 0, 0, 1,
               32'h0, 4'hF, 32'h0, 32'h0000_00AB, 0, 0, 1);
    // SW 0x44.
    run_access(0, 1, SZ_WORD, 0, 32'h44, 32'h1122_3344, 32'h0, 2, 0, 1,
               32'h44, 4'hF, 32'h1122_3344, 32'h0, 0, 0, 3);
    // Read and write together: treated as store, no load data.
    run_access(1, 1, SZ_WORD, 0, 32'h8, 32'h0BAD_F00D, 32'hFFFF_FFFF, 0, 0, 1,
               32'h8, 4'hF, 32'h0BAD_F00D, 32'h0, 0, 0, 1);
    // Reserved size code behaves as a word load.
    run_access(1, 0, 2'b11, 0, 32'h8, 32'h0, 32'h0000_0055, 2, 0, 1,
               32'h8, 4'hF, 32'h0, 32'h0000_0055, 0, 0, 3);

    // Reset during WAIT: request and stall must drop at once.
    req_q.push_back('{32'h30, 4'hF, 32'h0, 1'b0});
    @(posedge clk); #1;
    mem_read_in = 1'b1; mem_write_in = 1'b0; mem_size_in = SZ_WORD;
    addr_in = 32'h30; wdata_in = 32'h0; dmem_bus.dmem_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("wait_rst_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("wait_rst_stall", {31'd0, mem_stall}, 32'd0);
    mem_read_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    // Clean access right after reset.
    run_access(1, 0, SZ_BYTE, 0, 32'h0, 32'h0, 32'h0000_007F, 1, 0, 1,
               32'h0, 4'hF, 32'h0, 32'h0000_007F, 0, 0, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("req_queue_drained", req_q.size(), 32'd0);
    chk("done_queue_drained", done_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
